// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its operand sequencer:
// op-code encoding, data width and the sequencer state enum.
package alu_pkg;

  localparam int DW = 4;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_BMA = 3'd1;
  localparam logic [2:0] OP_AMB = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_SET = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Command-driven operand sequencer for the external 4-bit ALU: holds the
// accumulator, drives the ALU from registers and returns each result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [DW-1:0]    cmd_b,
  output logic [2:0]       alu_s,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  input  logic [DW-1:0]    alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. cmd_ready/res_valid depend on state only, so no input reaches
  // them combinationally; senders must hold valid and data until accepted.

  state_t           r_state;
  state_t           w_next_state;
  logic [DW-1:0]    r_acc;
  logic [2:0]       r_op_q;
  logic [DW-1:0]    r_b_q;
  logic [CNT_W-1:0] r_op_count;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_next_state = cmd_load ? RESP : EXEC;
        end
      end
      EXEC: w_next_state = RESP;
      RESP: begin
        if (res_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      IDLE:    cmd_ready = 1'b1;
      RESP:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // The ALU result is only trusted at the edge closing EXEC; operand
  // registers hold their values otherwise so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_op_q     <= '0;
      r_b_q      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_op_q <= cmd_op;
        r_b_q  <= cmd_b;
        if (cmd_load) begin
          r_acc <= cmd_b;
        end
      end
      if (r_state == EXEC) begin
        r_acc      <= alu_f;
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign alu_a    = r_acc;
  assign alu_b    = r_b_q;
  assign alu_s    = r_op_q;
  assign res_data = r_acc;
  assign res_zero = (r_acc == '0);
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 74381-style ALU
// connected beside it, as at the parent level.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_b;
  logic [2:0] alu_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_f;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic [7:0] op_count;

  int total;
  int bad;

  alu_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .alu_s     (alu_s),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .op_count  (op_count)
  );

  // ALU model
  always_comb begin
    alu_f = 4'h0;
    case (alu_s)
      3'd0: alu_f = 4'h0;
      3'd1: alu_f = alu_b - alu_a;
      3'd2: alu_f = alu_a - alu_b;
      3'd3: alu_f = alu_a + alu_b;
      3'd4: alu_f = alu_a ^ alu_b;
      3'd5: alu_f = alu_a | alu_b;
      3'd6: alu_f = alu_a & alu_b;
      default: alu_f = 4'hF;
    endcase
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one command and returns #1 after the accepting edge.
  task automatic issue(input logic load, input logic [2:0] op, input logic [3:0] b);
    logic ready_now;
    bit   done;
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_op    = op;
    cmd_b     = b;
    done      = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      ready_now = cmd_ready;
      step();
      if (ready_now) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: cmd_ready never 1, got %0b want 1", cmd_ready);
    end
    cmd_valid = 1'b0;
  endtask

  // Counts edges after acceptance until res_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    total++; if (res_data !== 4'h0) begin bad++; $display("FAIL reset_acc: got %h want 0", res_data); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", op_count); end
    total++; if ({alu_s, alu_b} !== 7'd0) begin bad++; $display("FAIL reset_alu_drive: got s=%0d b=%h want 0/0", alu_s, alu_b); end
  endtask

  task automatic test_load_add();
    int cyc;
    issue(1'b1, OP_CLR, 4'd5);
    wait_valid(cyc);
    total++; if (cyc !== 0) begin bad++; $display("FAIL load_latency: got %0d want 0", cyc); end
    total++; if (res_data !== 4'd5) begin bad++; $display("FAIL load5_data: got %h want 5", res_data); end
    consume();
    issue(1'b0, OP_ADD, 4'd4);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_exec_valid: got %0b want 0", res_valid); end
    wait_valid(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", cyc); end
    total++; if (res_data !== 4'd9) begin bad++; $display("FAIL add_data: got %h want 9", res_data); end
    total++; if (res_zero !== 1'b0) begin bad++; $display("FAIL add_zero: got %0b want 0", res_zero); end
    total++; if (op_count !== 8'd1) begin bad++; $display("FAIL add_count: got %0d want 1", op_count); end
    total++; if (alu_s !== OP_ADD || alu_b !== 4'd4) begin bad++; $display("FAIL add_drive: got s=%0d b=%h want 3/4", alu_s, alu_b); end
    consume();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add_ready_after: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_sub_wrap();
    int cyc;
    issue(1'b0, OP_AMB, 4'd9);
    wait_valid(cyc);
    total++; if (res_data !== 4'd0 || res_zero !== 1'b1) begin bad++; $display("FAIL amb_data: got %h z=%0b want 0 z=1", res_data, res_zero); end
    consume();
    issue(1'b0, OP_BMA, 4'd3);
    wait_valid(cyc);
    total++; if (res_data !== 4'd3 || res_zero !== 1'b0) begin bad++; $display("FAIL bma_data: got %h z=%0b want 3 z=0", res_data, res_zero); end
    consume();
    issue(1'b1, OP_CLR, 4'd15);
    wait_valid(cyc);
    consume();
    issue(1'b0, OP_ADD, 4'd1);
    wait_valid(cyc);
    total++; if (res_data !== 4'd0 || res_zero !== 1'b1) begin bad++; $display("FAIL add_wrap: got %h z=%0b want 0 z=1", res_data, res_zero); end
    total++; if (op_count !== 8'd4) begin bad++; $display("FAIL sub_count: got %0d want 4", op_count); end
    consume();
  endtask

  task automatic test_set_clr();
    int cyc;
    issue(1'b0, OP_SET, 4'd2);
    wait_valid(cyc);
    total++; if (res_data !== 4'hF) begin bad++; $display("FAIL set_data: got %h want f", res_data); end
    consume();
    issue(1'b0, OP_CLR, 4'd2);
    wait_valid(cyc);
    total++; if (res_data !== 4'h0 || res_zero !== 1'b1) begin bad++; $display("FAIL clr_data: got %h want 0", res_data); end
    consume();
    issue(1'b1, OP_ADD, 4'd7);
    wait_valid(cyc);
    total++; if (res_data !== 4'd7) begin bad++; $display("FAIL load7_data: got %h want 7", res_data); end
    total++; if (op_count !== 8'd6) begin bad++; $display("FAIL load7_count: got %0d want 6", op_count); end
    consume();
  endtask

  task automatic test_backpressure();
    int cyc;
    issue(1'b0, OP_ADD, 4'd2);
    wait_valid(cyc);
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_op    = OP_CLR;
    cmd_b     = 4'd3;
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1 || res_data !== 4'd9) begin bad++; $display("FAIL bp_hold[%0d]: got v=%0b d=%h want v=1 d=9", i, res_valid, res_data); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, cmd_ready); end
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got r=%0b v=%0b want r=1 v=0", cmd_ready, res_valid); end
    total++; if (res_data !== 4'd9) begin bad++; $display("FAIL bp_not_consumed: got %h want 9", res_data); end
    step();
    cmd_valid = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 4'd3) begin bad++; $display("FAIL bp_accept: got v=%0b d=%h want v=1 d=3", res_valid, res_data); end
    total++; if (op_count !== 8'd7) begin bad++; $display("FAIL bp_count: got %0d want 7", op_count); end
    consume();
  endtask

  task automatic test_reset_mid_exec();
    int cyc;
    issue(1'b1, OP_CLR, 4'd6);
    wait_valid(cyc);
    consume();
    issue(1'b0, OP_ADD, 4'd2);
    rst = 1'b1;
    #1;
    total++; if (res_data !== 4'd0) begin bad++; $display("FAIL rst_exec_acc: got %h want 0", res_data); end
    total++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_exec_hs: got v=%0b r=%0b want v=0 r=1", res_valid, cmd_ready); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rst_exec_count: got %0d want 0", op_count); end
    step();
    rst = 1'b0;
    step();
    total++; if (res_valid !== 1'b0 || res_data !== 4'd0 || op_count !== 8'd0) begin bad++; $display("FAIL rst_exec_after: got v=%0b d=%h c=%0d want 0/0/0", res_valid, res_data, op_count); end
  endtask

  task automatic test_count_wrap();
    int cyc;
    logic [3:0] exp_acc;
    exp_acc = 4'd0;
    for (int k = 1; k <= 256; k++) begin
      issue(1'b0, OP_ADD, 4'd1);
      wait_valid(cyc);
      exp_acc = exp_acc + 4'd1;
      total++; if (res_data !== exp_acc) begin bad++; $display("FAIL wrap_acc[%0d]: got %h want %h", k, res_data, exp_acc); end
      if (k == 255) begin
        total++; if (op_count !== 8'd255) begin bad++; $display("FAIL wrap_count255: got %0d want 255", op_count); end
      end
      consume();
    end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_count0: got %0d want 0", op_count); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'd0;
    cmd_b     = 4'd0;
    res_ready = 1'b0;
    test_reset();
    test_load_add();
    test_sub_wrap();
    test_set_clr();
    test_backpressure();
    test_reset_mid_exec();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
